// File: rtl/priority_bit_search_iter.sv
// Iterative highest/lowest set-bit search: one index bit resolved per clock by
// halving a left-aligned window. LSB searches run as MSB searches on the reversed word.
module priority_bit_search_iter #(
  parameter  int INPUT_WIDTH = 16,
  localparam int IDX_WIDTH   = $clog2(INPUT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] in_data,
  input  logic                   in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_WIDTH-1:0]   out_idx,
  output logic                   out_found
);

  if (INPUT_WIDTH < 2 || (INPUT_WIDTH & (INPUT_WIDTH - 1)) != 0) begin : g_bad_width
    $error("priority_bit_search_iter: INPUT_WIDTH must be a power of 2 and >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

  localparam logic [IDX_WIDTH-1:0] MAX_IDX  = IDX_WIDTH'(INPUT_WIDTH - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_STEP = IDX_WIDTH'(IDX_WIDTH - 1);

  state_t                 r_state, w_state_next;
  logic [INPUT_WIDTH-1:0] r_win, w_win_next;
  logic [IDX_WIDTH-1:0]   r_idx, w_idx_next;
  logic [IDX_WIDTH-1:0]   r_step, w_step_next;
  logic                   r_mode, w_mode_next;
  logic [IDX_WIDTH-1:0]   r_out_idx, w_out_idx_next;
  logic                   r_out_found, w_out_found_next;

  logic [INPUT_WIDTH-1:0] w_rev;
  logic [IDX_WIDTH:0]     w_half;
  logic [INPUT_WIDTH-1:0] w_mask;
  logic                   w_hit;
  logic [IDX_WIDTH-1:0]   w_idx_shift;

  genvar gi;
  for (gi = 0; gi < INPUT_WIDTH; gi++) begin : g_rev
    assign w_rev[gi] = in_data[INPUT_WIDTH-1-gi];
  end

  // Window stays left-aligned: the upper half is always the top h bits, and
  // choosing the lower half is a left shift by h.
  assign w_half      = (IDX_WIDTH+1)'(INPUT_WIDTH >> (r_step + 1'b1));
  assign w_mask      = ~({INPUT_WIDTH{1'b1}} >> w_half);
  assign w_hit       = |(r_win & w_mask);
  assign w_idx_shift = (r_idx << 1) | IDX_WIDTH'(w_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_win       <= '0;
      r_idx       <= '0;
      r_step      <= '0;
      r_mode      <= 1'b0;
      r_out_idx   <= '0;
      r_out_found <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_win       <= w_win_next;
      r_idx       <= w_idx_next;
      r_step      <= w_step_next;
      r_mode      <= w_mode_next;
      r_out_idx   <= w_out_idx_next;
      r_out_found <= w_out_found_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_win_next       = r_win;
    w_idx_next       = r_idx;
    w_step_next      = r_step;
    w_mode_next      = r_mode;
    w_out_idx_next   = r_out_idx;
    w_out_found_next = r_out_found;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_mode_next = in_mode;
          w_win_next  = in_mode ? w_rev : in_data;
          w_idx_next  = '0;
          w_step_next = '0;
          if (in_data == '0) begin
            w_state_next     = S_DONE;
            w_out_found_next = 1'b0;
            w_out_idx_next   = '0;
          end else begin
            w_state_next = S_SEARCH;
          end
        end
      end
      S_SEARCH: begin
        w_win_next  = w_hit ? r_win : (r_win << w_half);
        w_idx_next  = w_idx_shift;
        w_step_next = r_step + 1'b1;
        if (r_step == LAST_STEP) begin
          w_state_next     = S_DONE;
          w_out_found_next = 1'b1;
          w_out_idx_next   = r_mode ? (MAX_IDX - w_idx_shift) : w_idx_shift;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_idx   = r_out_idx;
  assign out_found = r_out_found;

endmodule

// File: tb/tb_priority_bit_search_iter.sv
// Directed bench for priority_bit_search_iter at widths 16, 2, 8 and 32.
module tb_priority_bit_search_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  int          sel = 0;          // 0: W=16, 1: W=2, 2: W=8, 3: W=32
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;

  logic       rdy16, val16, f16;  logic [3:0] idx16;
  logic       rdy2,  val2,  f2;   logic [0:0] idx2;
  logic       rdy8,  val8,  f8;   logic [2:0] idx8;
  logic       rdy32, val32, f32;  logic [4:0] idx32;
  logic       o_ready, o_valid, o_found;
  logic [4:0] o_idx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  priority_bit_search_iter #(.INPUT_WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(rdy16),
    .in_data(in_data[15:0]), .in_mode(in_mode), .out_valid(val16),
    .out_ready(out_ready), .out_idx(idx16), .out_found(f16));
  priority_bit_search_iter #(.INPUT_WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(rdy2),
    .in_data(in_data[1:0]), .in_mode(in_mode), .out_valid(val2),
    .out_ready(out_ready), .out_idx(idx2), .out_found(f2));
  priority_bit_search_iter #(.INPUT_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(rdy8),
    .in_data(in_data[7:0]), .in_mode(in_mode), .out_valid(val8),
    .out_ready(out_ready), .out_idx(idx8), .out_found(f8));
  priority_bit_search_iter #(.INPUT_WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 3), .in_ready(rdy32),
    .in_data(in_data), .in_mode(in_mode), .out_valid(val32),
    .out_ready(out_ready), .out_idx(idx32), .out_found(f32));

  always_comb begin
    o_ready = rdy16; o_valid = val16; o_found = f16; o_idx = {1'b0, idx16};
    case (sel)
      1: begin o_ready = rdy2;  o_valid = val2;  o_found = f2;  o_idx = {4'b0, idx2}; end
      2: begin o_ready = rdy8;  o_valid = val8;  o_found = f8;  o_idx = {2'b0, idx8}; end
      3: begin o_ready = rdy32; o_valid = val32; o_found = f32; o_idx = idx32; end
      default: ;
    endcase
  end

  // Reference: index of highest (m=0) or lowest (m=1) set bit among w bits.
  function automatic int ref_idx(input logic [31:0] d, input int w, input logic m);
    int r = 0;
    if (m) begin
      for (int i = w - 1; i >= 0; i--) if (d[i]) r = i;
    end else begin
      for (int i = 0; i < w; i++) if (d[i]) r = i;
    end
    return r;
  endfunction

  // Drives one word, waits for the result and consumes it. lat = edges after
  // the accepting edge until out_valid is seen.
  task automatic send(input logic [31:0] d, input logic m, input logic hold_ready,
                      output int lat, output logic [4:0] idx, output logic f);
    int guard = 0;
    while (!o_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    n_checks++;
    if (!o_ready) begin
      n_fail++;
      $display("FAIL in_ready_wait: in_ready=%b required 1", o_ready);
    end
    in_data = d; in_mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    idx = o_idx; f = o_found;
    $display("txn sel=%0d data=%h mode=%0d -> idx=%0d found=%0d lat=%0d", sel, d, m, idx, f, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    if (!hold_ready) out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (rdy16 !== 1'b1 || val16 !== 1'b0 || f16 !== 1'b0 || idx16 !== 4'd0) begin
      n_fail++;
      $display("FAIL reset16: ready=%b valid=%b found=%b idx=%0d required 1 0 0 0", rdy16, val16, f16, idx16);
    end
    n_checks++;
    if ({rdy2, rdy8, rdy32} !== 3'b111 || {val2, val8, val32} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_sweep: ready=%b%b%b valid=%b%b%b required 111 000", rdy2, rdy8, rdy32, val2, val8, val32);
    end
    rst = 1'b0;
  endtask

  task automatic test_msb();
    logic [15:0] vd [4] = '{16'h16DE, 16'h87CA, 16'h0124, 16'h0001};
    int          ve [4] = '{12, 15, 8, 0};
    int lat; logic [4:0] idx; logic f;
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      send({16'h0, vd[i]}, 1'b0, 1'b0, lat, idx, f);
      n_checks++;
      if (lat !== 4 || idx !== 5'(ve[i]) || f !== 1'b1) begin
        n_fail++;
        $display("FAIL msb16_%h: idx=%0d found=%0d lat=%0d required %0d 1 4", vd[i], idx, f, lat, ve[i]);
      end
    end
  endtask

  task automatic test_lsb();
    logic [15:0] vd [4] = '{16'h16DE, 16'h0124, 16'h8000, 16'h0001};
    int          ve [4] = '{1, 2, 15, 0};
    int lat; logic [4:0] idx; logic f;
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      send({16'h0, vd[i]}, 1'b1, 1'b0, lat, idx, f);
      n_checks++;
      if (lat !== 4 || idx !== 5'(ve[i]) || f !== 1'b1) begin
        n_fail++;
        $display("FAIL lsb16_%h: idx=%0d found=%0d lat=%0d required %0d 1 4", vd[i], idx, f, lat, ve[i]);
      end
    end
  endtask

  task automatic test_zero();
    int lat; logic [4:0] idx; logic f;
    sel = 0;
    for (int m = 0; m < 2; m++) begin
      send(32'h0, m[0], 1'b0, lat, idx, f);
      n_checks++;
      if (lat !== 0 || idx !== 5'd0 || f !== 1'b0) begin
        n_fail++;
        $display("FAIL zero16_m%0d: idx=%0d found=%0d lat=%0d required 0 0 0", m, idx, f, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard = 0;
    logic ok;
    sel = 0;
    in_data = 32'h0124; in_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 32'hFFFF;  // held valid with different data; must be ignored
    while (!o_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_idx !== 5'd8 || o_found !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_c%0d: valid=%b ready=%b idx=%0d found=%b required 1 0 8 1", c, o_valid, o_ready, o_idx, o_found);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL release: ready=%b valid=%b required 1 0", o_ready, o_valid);
    end
    ok = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] vd [10] = '{16'h16DE, 16'h87CA, 16'h0124, 16'h0001, 16'h8000,
                             16'h16DE, 16'h0124, 16'h8000, 16'h00F0, 16'h4002};
    logic        vm [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int          ve [10] = '{12, 15, 8, 0, 15, 1, 2, 15, 4, 1};
    int lat; logic [4:0] idx; logic f;
    int c0;
    sel = 0;
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      send({16'h0, vd[i]}, vm[i], 1'b1, lat, idx, f);
      n_checks++;
      if (idx !== 5'(ve[i]) || f !== 1'b1 || lat !== 4) begin
        n_fail++;
        $display("FAIL b2b_%0d: idx=%0d found=%0d lat=%0d required %0d 1 4", i, idx, f, lat, ve[i]);
      end
    end
    out_ready = 1'b0;
    n_checks++;
    if (cyc - c0 !== 60) begin
      n_fail++;
      $display("FAIL b2b_throughput: cycles=%0d required 60", cyc - c0);
    end
  endtask

  task automatic test_reset_mid_search();
    logic seen;
    int lat; logic [4:0] idx; logic f;
    sel = 0;
    in_data = 32'h87CA; in_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: ready=%b valid=%b required 1 0", o_ready, o_valid);
    end
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (o_valid) seen = 1'b1; end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stale: out_valid seen=%b required 0", seen);
    end
    send(32'h0124, 1'b0, 1'b0, lat, idx, f);
    n_checks++;
    if (idx !== 5'd8 || f !== 1'b1 || lat !== 4) begin
      n_fail++;
      $display("FAIL rst_after: idx=%0d found=%0d lat=%0d required 8 1 4", idx, f, lat);
    end
  endtask

  task automatic test_sweep();
    int          vs [10] = '{1, 1, 1, 1, 2, 2, 2, 3, 3, 3};
    logic [31:0] vd [10] = '{32'h2, 32'h2, 32'h3, 32'h1, 32'h5A, 32'h5A, 32'h80,
                             32'h0004_0100, 32'h0004_0100, 32'h8000_0001};
    logic        vm [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int          ve [10] = '{1, 1, 0, 0, 6, 1, 7, 18, 8, 31};
    int          vl [4]  = '{4, 1, 3, 5};
    int          vw [4]  = '{16, 2, 8, 32};
    int lat; logic [4:0] idx; logic f;
    logic [31:0] d;
    logic m;
    for (int i = 0; i < 10; i++) begin
      sel = vs[i];
      send(vd[i], vm[i], 1'b0, lat, idx, f);
      n_checks++;
      if (idx !== 5'(ve[i]) || f !== 1'b1 || lat !== vl[sel]) begin
        n_fail++;
        $display("FAIL sweep_%0d: idx=%0d found=%0d lat=%0d required %0d 1 %0d", i, idx, f, lat, ve[i], vl[sel]);
      end
    end
    for (int i = 0; i < 12; i++) begin
      sel = 1 + (i % 3);
      d = $urandom();
      if (vw[sel] < 32) d = d & ((32'h1 << vw[sel]) - 32'h1);
      if (d == 32'h0) d = 32'h1;
      m = i[0];
      send(d, m, 1'b0, lat, idx, f);
      n_checks++;
      if (idx !== 5'(ref_idx(d, vw[sel], m)) || f !== 1'b1 || lat !== vl[sel]) begin
        n_fail++;
        $display("FAIL rand_%0d: idx=%0d found=%0d lat=%0d required %0d 1 %0d", i, idx, f, lat,
                 ref_idx(d, vw[sel], m), vl[sel]);
      end
    end
    sel = 3;
    send(32'h0, 1'b1, 1'b0, lat, idx, f);
    n_checks++;
    if (idx !== 5'd0 || f !== 1'b0 || lat !== 0) begin
      n_fail++;
      $display("FAIL zero32: idx=%0d found=%0d lat=%0d required 0 0 0", idx, f, lat);
    end
  endtask

  initial begin
    test_reset();
    test_msb();
    test_lsb();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_search();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
